matrix_elementwise_unit: RTL and testbench

//  Parametrised element-wise matrix engine: c[r][k] = op(a[r][k], b[r][k]) over a ROWS x COLS tile.

---
 rtl/matrix_pkg.sv | 33 +++
 rtl/matrix_ew_alu.sv | 53 +++++
 rtl/matrix_elementwise_unit.sv | 145 ++++++++++++++
 tb/tb_matrix_elementwise_unit.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_pkg.sv
// matrix_pkg
// Shared types for the element-wise matrix engine:
//   mat_op_e    - operation select (ADD, SUB, MAX, MIN), encoded as on op_mode
//   mat_state_e - top-level sequencer state
//   rc_t        - row/column pair produced by flat_to_rc()
package matrix_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MAX = 2'b10,
        OP_MIN = 2'b11
    } mat_op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } mat_state_e;

    typedef struct packed {
        int row;
        int col;
    } rc_t;

    // Row-major flat index -> (row, col).
    function automatic rc_t flat_to_rc(input int flat, input int cols);
        rc_t v_rc;
        v_rc.row = flat / cols;
        v_rc.col = flat % cols;
        return v_rc;
    endfunction

endpackage

// File: rtl/matrix_ew_alu.sv
// matrix_ew_alu
// One combinational element-wise lane: o_res = op(i_a, i_b).
// Configuration macro: MATRIX_EW_SAT_EN (ADD clamps high, SUB clamps at zero).
// Ports:
//   i_op  - operation select
//   i_a   - operand A, unsigned IN_W
//   i_b   - operand B, unsigned IN_W
//   o_res - result, OUT_W
module matrix_ew_alu
    import matrix_pkg::*;
#(
    parameter int IN_W  = 8,
    parameter int OUT_W = 16
) (
    input  mat_op_e          i_op,
    input  logic [IN_W-1:0]  i_a,
    input  logic [IN_W-1:0]  i_b,
    output logic [OUT_W-1:0] o_res
);

    logic             w_a_gt_b;
    logic [OUT_W-1:0] w_add;
    logic [OUT_W-1:0] w_sub;

    assign w_a_gt_b = (i_a > i_b);

`ifdef MATRIX_EW_SAT_EN
    logic [OUT_W:0] w_sum;
    logic [OUT_W:0] w_diff;

    assign w_sum  = (OUT_W+1)'(i_a) + (OUT_W+1)'(i_b);
    assign w_diff = (OUT_W+1)'(i_a) - (OUT_W+1)'(i_b);
    // Carry out of OUT_W means overflow; MSB of the difference means a borrow (negative).
    assign w_add  = w_sum[OUT_W]  ? '1 : w_sum[OUT_W-1:0];
    assign w_sub  = w_diff[OUT_W] ? '0 : w_diff[OUT_W-1:0];
`else
    // Plain wrap: the extension bit would be discarded anyway, so compute at OUT_W.
    assign w_add = OUT_W'(i_a) + OUT_W'(i_b);
    assign w_sub = OUT_W'(i_a) - OUT_W'(i_b);
`endif

    always_comb begin
        o_res = '0;
        case (i_op)
            OP_ADD:  o_res = w_add;
            OP_SUB:  o_res = w_sub;
            OP_MAX:  o_res = OUT_W'(w_a_gt_b ? i_a : i_b);
            OP_MIN:  o_res = OUT_W'(w_a_gt_b ? i_b : i_a);
            default: o_res = '0;
        endcase
    end

endmodule

// File: rtl/matrix_elementwise_unit.sv
// matrix_elementwise_unit
// Element-wise matrix engine: c[r][k] = op(a[r][k], b[r][k]) over a ROWS x COLS tile,
// LANES elements per clock in row-major order, start/busy/done handshake.
// Configuration macro: MATRIX_EW_SAT_EN (saturating ADD/SUB inside each lane).
// Ports:
//   clk     - clock, rising edge
//   rst     - synchronous active-high reset
//   start   - request a pass, honoured only in IDLE
//   op_mode - 00 ADD, 01 SUB, 10 MAX, 11 MIN; latched when start is accepted
//   a, b    - operand tiles, held stable while busy
//   c       - registered result tile
//   busy    - high while a pass is running
//   done    - sticky completion flag, cleared by the next accepted start
//
// state  | meaning
// S_IDLE | waiting for start; c and done hold their values
// S_RUN  | writing one group of LANES elements per clock
module matrix_elementwise_unit
    import matrix_pkg::*;
#(
    parameter int ROWS  = 4,
    parameter int COLS  = 4,
    parameter int IN_W  = 8,
    parameter int OUT_W = 16,
    parameter int LANES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op_mode,
    input  logic [IN_W-1:0]  a [ROWS][COLS],
    input  logic [IN_W-1:0]  b [ROWS][COLS],
    output logic [OUT_W-1:0] c [ROWS][COLS],
    output logic             busy,
    output logic             done
);

    localparam int N  = ROWS * COLS;
    localparam int IW = $clog2(N + 1);

    generate
        if (LANES < 1 || (N % LANES) != 0) begin : g_bad_lanes
            $error("matrix_elementwise_unit: LANES must divide ROWS*COLS");
        end
    endgenerate

    localparam logic [IW-1:0] LAST_IDX = IW'(N - LANES);

    mat_state_e       r_state;
    logic [IW-1:0]    r_idx;
    mat_op_e          r_op;
    logic             r_busy;
    logic             r_done;

    logic [IN_W-1:0]  w_a   [LANES];
    logic [IN_W-1:0]  w_b   [LANES];
    logic [OUT_W-1:0] w_res [LANES];
    logic [OUT_W-1:0] w_c_next [ROWS][COLS];
    rc_t              w_rc_rd;
    rc_t              w_rc_wr;

    // Element e always lands on lane e%LANES, in the group whose base index is e-e%LANES.
    always_comb begin
        w_a     = '{default: '0};
        w_b     = '{default: '0};
        w_rc_rd = '0;
        for (int e = 0; e < N; e++) begin
            w_rc_rd = flat_to_rc(e, COLS);
            if (r_idx == IW'(e - (e % LANES))) begin
                w_a[e % LANES] = a[w_rc_rd.row][w_rc_rd.col];
                w_b[e % LANES] = b[w_rc_rd.row][w_rc_rd.col];
            end
        end
    end

    generate
        for (genvar l = 0; l < LANES; l++) begin : g_lane
            matrix_ew_alu #(
                .IN_W  (IN_W),
                .OUT_W (OUT_W)
            ) u_alu (
                .i_op  (r_op),
                .i_a   (w_a[l]),
                .i_b   (w_b[l]),
                .o_res (w_res[l])
            );
        end
    endgenerate

    // Only the current group changes; everything else keeps its previous result.
    always_comb begin
        w_c_next = c;
        w_rc_wr  = '0;
        if (r_state == S_RUN) begin
            for (int e = 0; e < N; e++) begin
                w_rc_wr = flat_to_rc(e, COLS);
                if (r_idx == IW'(e - (e % LANES))) begin
                    w_c_next[w_rc_wr.row][w_rc_wr.col] = w_res[e % LANES];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_op    <= OP_ADD;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            for (int r = 0; r < ROWS; r++) begin
                for (int k = 0; k < COLS; k++) begin
                    c[r][k] <= '0;
                end
            end
        end else begin
            c <= w_c_next;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_RUN;
                        r_idx   <= '0;
                        r_op    <= mat_op_e'(op_mode);
                        r_done  <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (r_idx == LAST_IDX) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_idx <= r_idx + IW'(LANES);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: tb/tb_matrix_elementwise_unit.sv
module tb_matrix_elementwise_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // default instance: 4x4, 8->16, 1 lane
    logic        start_d;
    logic [1:0]  op_d;
    logic [7:0]  a_d [4][4];
    logic [7:0]  b_d [4][4];
    logic [15:0] c_d [4][4];
    logic        busy_d, done_d;

    // narrow-output instance: OUT_W=8
    logic        start_8;
    logic [1:0]  op_8;
    logic [7:0]  a_8 [4][4];
    logic [7:0]  b_8 [4][4];
    logic [7:0]  c_8 [4][4];
    logic        busy_8, done_8;

    // four-lane instance
    logic        start_4;
    logic [1:0]  op_4;
    logic [7:0]  a_4 [4][4];
    logic [7:0]  b_4 [4][4];
    logic [15:0] c_4 [4][4];
    logic        busy_4, done_4;

    matrix_elementwise_unit u_dut_d (
        .clk(clk), .rst(rst), .start(start_d), .op_mode(op_d),
        .a(a_d), .b(b_d), .c(c_d), .busy(busy_d), .done(done_d)
    );

    matrix_elementwise_unit #(.OUT_W(8)) u_dut_8 (
        .clk(clk), .rst(rst), .start(start_8), .op_mode(op_8),
        .a(a_8), .b(b_8), .c(c_8), .busy(busy_8), .done(done_8)
    );

    matrix_elementwise_unit #(.LANES(4)) u_dut_4 (
        .clk(clk), .rst(rst), .start(start_4), .op_mode(op_4),
        .a(a_4), .b(b_4), .c(c_4), .busy(busy_4), .done(done_4)
    );

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_q [$];

    function automatic logic [31:0] model(input logic [1:0] op, input int av, input int bv, input int ow);
        int mx;
        int r;
        mx = (1 << ow) - 1;
        r  = 0;
        case (op)
            2'b00: begin
                r = av + bv;
`ifdef MATRIX_EW_SAT_EN
                if (r > mx) r = mx;
`endif
            end
            2'b01: begin
                r = av - bv;
`ifdef MATRIX_EW_SAT_EN
                if (r < 0) r = 0;
`endif
            end
            2'b10: r = (av > bv) ? av : bv;
            default: r = (av < bv) ? av : bv;
        endcase
        return 32'(r & mx);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go_d(input logic [1:0] op, input bit push);
        if (push)
            for (int r = 0; r < 4; r++)
                for (int k = 0; k < 4; k++)
                    exp_q.push_back(model(op, a_d[r][k], b_d[r][k], 16));
        op_d    = op;
        start_d = 1'b1;
        tick();
        start_d = 1'b0;
    endtask

    task automatic wait_d(output int nb);
        nb = 0;
        while (busy_d === 1'b1 && nb < 200) begin
            nb++;
            tick();
        end
    endtask

    task automatic test_reset();
        int nz;
        rst = 1'b1;
        tick();
        tick();
        nz = 0;
        for (int r = 0; r < 4; r++)
            for (int k = 0; k < 4; k++)
                if (c_d[r][k] !== 16'd0 || c_8[r][k] !== 8'd0 || c_4[r][k] !== 16'd0) nz++;
        checks++;
        if ({busy_d, busy_8, busy_4} !== 3'b000) begin
            failures++; $display("FAIL reset_busy got=%b want=000", {busy_d, busy_8, busy_4});
        end
        checks++;
        if ({done_d, done_8, done_4} !== 3'b000) begin
            failures++; $display("FAIL reset_done got=%b want=000", {done_d, done_8, done_4});
        end
        checks++;
        if (nz !== 0) begin
            failures++; $display("FAIL reset_c nonzero_elems=%0d want=0", nz);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_add();
        int nb;
        logic [31:0] v;
        for (int r = 0; r < 4; r++)
            for (int k = 0; k < 4; k++) begin
                a_d[r][k] = 8'(r * 4 + k);
                b_d[r][k] = 8'd255;
            end
        go_d(2'b00, 1'b1);
        wait_d(nb);
        checks++;
        if (nb !== 16) begin
            failures++; $display("FAIL add_busy_cycles got=%0d want=16", nb);
        end
        checks++;
        if (done_d !== 1'b1) begin
            failures++; $display("FAIL add_done got=%b want=1", done_d);
        end
        checks++;
        if (c_d[3][3] !== 16'd270) begin
            failures++; $display("FAIL add_c33 got=%0d want=270", c_d[3][3]);
        end
        checks++;
        if (c_d[0][0] !== 16'd255) begin
            failures++; $display("FAIL add_c00 got=%0d want=255", c_d[0][0]);
        end
        for (int r = 0; r < 4; r++)
            for (int k = 0; k < 4; k++) begin
                v = exp_q.pop_front();
                checks++;
                if (c_d[r][k] !== v[15:0]) begin
                    failures++; $display("FAIL add_sb[%0d][%0d] got=%0d want=%0d", r, k, c_d[r][k], v[15:0]);
                end
            end
    endtask

    task automatic test_sub();
        int nb;
        logic [31:0] v;
        logic [15:0] want;
`ifdef MATRIX_EW_SAT_EN
        want = 16'h0000;
`else
        want = 16'hFFFF;
`endif
        for (int r = 0; r < 4; r++)
            for (int k = 0; k < 4; k++) begin
                a_d[r][k] = 8'd1;
                b_d[r][k] = 8'd2;
            end
        go_d(2'b01, 1'b1);
        wait_d(nb);
        checks++;
        if (nb !== 16) begin
            failures++; $display("FAIL sub_busy_cycles got=%0d want=16", nb);
        end
        checks++;
        if (c_d[2][1] !== want) begin
            failures++; $display("FAIL sub_c21 got=%h want=%h", c_d[2][1], want);
        end
        for (int r = 0; r < 4; r++)
            for (int k = 0; k < 4; k++) begin
                v = exp_q.pop_front();
                checks++;
                if (c_d[r][k] !== v[15:0]) begin
                    failures++; $display("FAIL sub_sb[%0d][%0d] got=%h want=%h", r, k, c_d[r][k], v[15:0]);
                end
            end
    endtask

    task automatic test_ignored_start();
        int nb;
        int rises;
        logic prev;
        logic [31:0] v;
        for (int r = 0; r < 4; r++)
            for (int k = 0; k < 4; k++) begin
                a_d[r][k] = 8'(r * 4 + k + 10);
                b_d[r][k] = 8'd3;
            end
        prev  = done_d;
        rises = 0;
        go_d(2'b00, 1'b1);
        nb = 1;
        for (int i = 0; i < 4; i++) begin
            if (busy_d === 1'b1) nb++;
            tick();
        end
        start_d = 1'b1;
        op_d    = 2'b01;
        tick();
        start_d = 1'b0;
        prev    = 1'b0;
        while (busy_d === 1'b1 && nb < 200) begin
            nb++;
            tick();
        end
        for (int i = 0; i < 6; i++) begin
            if (done_d === 1'b1 && prev !== 1'b1) rises++;
            prev = done_d;
            if (busy_d !== 1'b0) rises += 10;
            tick();
        end
        checks++;
        if (nb !== 16) begin
            failures++; $display("FAIL ign_busy_cycles got=%0d want=16", nb);
        end
        checks++;
        if (rises !== 1) begin
            failures++; $display("FAIL ign_done_once events=%0d want=1", rises);
        end
        for (int r = 0; r < 4; r++)
            for (int k = 0; k < 4; k++) begin
                v = exp_q.pop_front();
                checks++;
                if (c_d[r][k] !== v[15:0]) begin
                    failures++; $display("FAIL ign_sb[%0d][%0d] got=%0d want=%0d", r, k, c_d[r][k], v[15:0]);
                end
            end
    endtask

    task automatic test_reset_mid();
        int nb;
        int nz;
        logic [31:0] v;
        for (int r = 0; r < 4; r++)
            for (int k = 0; k < 4; k++) begin
                a_d[r][k] = 8'd5;
                b_d[r][k] = 8'd7;
            end
        go_d(2'b00, 1'b0);
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b1;
        tick();
        nz = 0;
        for (int r = 0; r < 4; r++)
            for (int k = 0; k < 4; k++)
                if (c_d[r][k] !== 16'd0) nz++;
        checks++;
        if (busy_d !== 1'b0) begin
            failures++; $display("FAIL rstmid_busy got=%b want=0", busy_d);
        end
        checks++;
        if (done_d !== 1'b0) begin
            failures++; $display("FAIL rstmid_done got=%b want=0", done_d);
        end
        checks++;
        if (nz !== 0) begin
            failures++; $display("FAIL rstmid_c nonzero_elems=%0d want=0", nz);
        end
        rst = 1'b0;
        tick();
        for (int r = 0; r < 4; r++)
            for (int k = 0; k < 4; k++) begin
                a_d[r][k] = 8'(r * 16 + k * 3);
                b_d[r][k] = 8'(200 - r * 9);
            end
        go_d(2'b00, 1'b1);
        wait_d(nb);
        checks++;
        if (nb !== 16 || done_d !== 1'b1) begin
            failures++; $display("FAIL rstmid_pass busy_cycles=%0d done=%b want 16/1", nb, done_d);
        end
        for (int r = 0; r < 4; r++)
            for (int k = 0; k < 4; k++) begin
                v = exp_q.pop_front();
                checks++;
                if (c_d[r][k] !== v[15:0]) begin
                    failures++; $display("FAIL rstmid_sb[%0d][%0d] got=%0d want=%0d", r, k, c_d[r][k], v[15:0]);
                end
            end
    endtask

    task automatic test_overflow8();
        int nb;
        logic [31:0] v;
        logic [7:0] want;
`ifdef MATRIX_EW_SAT_EN
        want = 8'd255;
`else
        want = 8'd144;
`endif
        for (int r = 0; r < 4; r++)
            for (int k = 0; k < 4; k++) begin
                a_8[r][k] = 8'd200;
                b_8[r][k] = 8'd200;
                exp_q.push_back(model(2'b00, 200, 200, 8));
            end
        op_8    = 2'b00;
        start_8 = 1'b1;
        tick();
        start_8 = 1'b0;
        nb = 0;
        while (busy_8 === 1'b1 && nb < 200) begin
            nb++;
            tick();
        end
        checks++;
        if (nb !== 16 || done_8 !== 1'b1) begin
            failures++; $display("FAIL ovf8_pass busy_cycles=%0d done=%b want 16/1", nb, done_8);
        end
        checks++;
        if (c_8[1][2] !== want) begin
            failures++; $display("FAIL ovf8_c12 got=%0d want=%0d", c_8[1][2], want);
        end
        for (int r = 0; r < 4; r++)
            for (int k = 0; k < 4; k++) begin
                v = exp_q.pop_front();
                checks++;
                if (c_8[r][k] !== v[7:0]) begin
                    failures++; $display("FAIL ovf8_sb[%0d][%0d] got=%0d want=%0d", r, k, c_8[r][k], v[7:0]);
                end
            end
    endtask

    task automatic test_back_to_back();
        int nb;
        logic [31:0] v;
        for (int r = 0; r < 4; r++)
            for (int k = 0; k < 4; k++) begin
                a_4[r][k] = 8'd10;
                b_4[r][k] = 8'd20;
            end
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 16; i++)
                exp_q.push_back(model((pass == 0) ? 2'b10 : 2'b11, 10, 20, 16));
            op_4    = (pass == 0) ? 2'b10 : 2'b11;
            start_4 = 1'b1;
            tick();
            start_4 = 1'b0;
            if (pass == 1) begin
                checks++;
                if (busy_4 !== 1'b1 || done_4 !== 1'b0) begin
                    failures++; $display("FAIL b2b_accept busy=%b done=%b want 1/0", busy_4, done_4);
                end
            end
            nb = 0;
            while (busy_4 === 1'b1 && nb < 200) begin
                nb++;
                tick();
            end
            checks++;
            if (nb !== 4) begin
                failures++; $display("FAIL b2b_busy_cycles pass=%0d got=%0d want=4", pass, nb);
            end
            checks++;
            if (done_4 !== 1'b1) begin
                failures++; $display("FAIL b2b_done pass=%0d got=%b want=1", pass, done_4);
            end
            for (int r = 0; r < 4; r++)
                for (int k = 0; k < 4; k++) begin
                    v = exp_q.pop_front();
                    checks++;
                    if (c_4[r][k] !== v[15:0]) begin
                        failures++; $display("FAIL b2b_sb pass=%0d [%0d][%0d] got=%0d want=%0d", pass, r, k, c_4[r][k], v[15:0]);
                    end
                end
        end
    endtask

    initial begin
        rst     = 1'b1;
        start_d = 1'b0; op_d = 2'b00;
        start_8 = 1'b0; op_8 = 2'b00;
        start_4 = 1'b0; op_4 = 2'b00;
        for (int r = 0; r < 4; r++)
            for (int k = 0; k < 4; k++) begin
                a_d[r][k] = '0; b_d[r][k] = '0;
                a_8[r][k] = '0; b_8[r][k] = '0;
                a_4[r][k] = '0; b_4[r][k] = '0;
            end
        test_reset();
        test_add();
        test_sub();
        test_ignored_start();
        test_reset_mid();
        test_overflow8();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
